kbd_scancode_decoder: RTL and testbench
=======================================

# kbd_scancode_decoder

Consumes bytes from the PS/2 bit receiver (`din` / `new_din` strobe) and turns Set-2 scan-code sequences into single-cycle key make/break events with a 9-bit key code (`keyCode[8]` = E0-extended). It sits directly downstream of the receiver and upstream of the game's key-state logic. It resolves prefixes (E0, F0, E0 F0), swallows the Pause (E1) sequence, drops fake-shift and keyboard status bytes, and aborts stale prefixes on a timeout.

## Interface
- `TIMEOUT_CYCLES`, default 200_000: cycles without a new byte after which a partial sequence is aborted (4 ms @ 50 MHz).
- `clk`  in  1  system clock; single clock domain.
- `resetN`  in  1  synchronous, active-low reset.
- `din`  in  8  byte from the receiver; valid when `new_din`=1.
- `new_din`  in  1  one-cycle strobe; every cycle it is high counts as one byte.
- `keyCode`  out  9  {extended, code}; updated only on an event, held otherwise.
- `make`  out  1  one-cycle pulse: key pressed.
- `brakk`  out  1  one-cycle pulse: key released.
- `busy`  out  1  high when state ≠ IDLE_ST (partial sequence pending).

## Operation
- States: IDLE_ST, EXT_ST, BRK_ST, EXT_BRK_ST, PAUSE_ST. Transitions occur only on cycles with `new_din`=1, except timeout.
- Ignored set IGN = {0x00, 0xFF, 0xAA, 0xFA, 0xEE, 0xFE}. An IGN byte in any state → IDLE_ST, no event.
- IDLE_ST: 0xE0 → EXT_ST. 0xF0 → BRK_ST. 0xE1 → PAUSE_ST with skip counter = 7. Any other byte → `make`, `keyCode`={0,din}; stay IDLE_ST.
- EXT_ST: 0xF0 → EXT_BRK_ST. 0xE0 → stay EXT_ST. 0x12 (fake shift) → IDLE_ST, no event. 0xE1 → IDLE_ST, no event. Other → `make`, {1,din}, IDLE_ST.
- BRK_ST: 0xE0/0xF0/0xE1 → IDLE_ST, no event, byte discarded. Other → `brakk`, {0,din}, IDLE_ST.
- EXT_BRK_ST: 0x12 or 0xE0/0xF0/0xE1 → IDLE_ST, no event. Other → `brakk`, {1,din}, IDLE_ST.
- PAUSE_ST: each byte decrements skip; the byte that brings skip to 0 → `make`, `keyCode`=PAUSE_CODE (9'h177), IDLE_ST. No break is ever emitted for Pause. IGN bytes abort as above.
- Timeout: the 18-bit idle counter clears on every `new_din` and in IDLE_ST, and counts otherwise. When it reaches TIMEOUT_CYCLES-1 → IDLE_ST, no event. Skip counter and prefix state are discarded.
- `make` and `brakk` are never high together.

## Timing
- Reset (`resetN`=0 at a clk edge): state IDLE_ST, `keyCode`=9'h000, `make`=0, `brakk`=0, `busy`=0, counters 0. Reset applies mid-sequence with the same result.
- Latency: `new_din` sampled at edge N → `make`/`brakk` high for exactly cycle N+1. `keyCode` changes at the same edge.
- `busy` reflects the registered state: high from the edge after a prefix byte until the edge that returns to IDLE_ST.
- `new_din` on the same cycle as the timeout terminal count: the byte is processed normally and the timeout is ignored.
- Back-to-back `new_din` on consecutive cycles must be handled: one transition per cycle, with possible event pulses on consecutive cycles.

## Structure
- Shared `kbd_pkg`: state enum, byte constants (KBD_EXT=0xE0, KBD_BRK=0xF0, KBD_PAUSE=0xE1, KBD_FAKE_SHIFT=0x12), PAUSE_CODE, and an `is_ign(byte)` function.
- Flat module: one registered FSM, one `always_comb` next-state/output block, and an inline timeout counter and skip counter. No sub-module.

## Test plan
- Byte 0x1C → `make` pulse one cycle later with `keyCode`=0x01C; `brakk`=0; `busy` stays 0.
- F0, 1C → no event on F0, `busy`=1. On 1C: `brakk`, `keyCode`=0x01C.
- E0, F0, 75 → single `brakk`, `keyCode`=0x175. E0, 75 → `make` 0x175.
- Print Screen E0 12 E0 7C → exactly one `make`, 0x17C. The release sequence E0 F0 7C E0 F0 12 → exactly one `brakk`, 0x17C.
- E1 14 77 E1 F0 14 F0 77 → exactly one `make`, 0x177 on the 8th byte, no `brakk`, `busy`=0 afterwards. Also 0xFA/0xAA in IDLE_ST → no event.
- E0 followed by TIMEOUT_CYCLES idle cycles → `busy` drops, then 1C → `make` 0x01C (not extended). F0 followed by `resetN` low one cycle, then 1C → `make` 0x01C.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code decoder.
package kbd_pkg;

    typedef enum logic [2:0] {
        IDLE_ST,
        EXT_ST,
        BRK_ST,
        EXT_BRK_ST,
        PAUSE_ST
    } kbd_state_t;

    localparam logic [7:0] KBD_EXT        = 8'hE0;
    localparam logic [7:0] KBD_BRK        = 8'hF0;
    localparam logic [7:0] KBD_PAUSE      = 8'hE1;
    localparam logic [7:0] KBD_FAKE_SHIFT = 8'h12;

    localparam logic [8:0] PAUSE_CODE     = 9'h177;
    // Bytes still to swallow after the leading E1 of the Pause sequence.
    localparam logic [2:0] PAUSE_SKIP     = 3'd7;

    // Keyboard status / filler bytes that never belong to a key sequence.
    function automatic logic is_ign(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA) ||
               (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE);
    endfunction

endpackage

// File: rtl/kbd_scancode_decoder.sv
// Turns Set-2 scan-code byte sequences into make/break key events.
module kbd_scancode_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] din,
    input  logic       new_din,
    output logic [8:0] keyCode,
    output logic       make,
    output logic       brakk,
    output logic       busy
);

    localparam logic [17:0] TO_LAST = 18'(TIMEOUT_CYCLES - 1);

    kbd_state_t  state, state_nx;
    logic [2:0]  skip_cnt, skip_nx;
    logic [17:0] idle_cnt, idle_nx;
    logic [8:0]  code_nx;
    logic        make_nx, brakk_nx;

    // Next-state, event and counter decode; a byte always wins over the timeout.
    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        code_nx  = keyCode;
        make_nx  = 1'b0;
        brakk_nx = 1'b0;
        idle_nx  = (new_din || state == IDLE_ST) ? '0 : idle_cnt + 18'd1;

        if (new_din) begin
            if (is_ign(din)) begin
                state_nx = IDLE_ST;
                skip_nx  = '0;
            end else begin
                case (state)
                    IDLE_ST: begin
                        if (din == KBD_EXT) begin
                            state_nx = EXT_ST;
                        end else if (din == KBD_BRK) begin
                            state_nx = BRK_ST;
                        end else if (din == KBD_PAUSE) begin
                            state_nx = PAUSE_ST;
                            skip_nx  = PAUSE_SKIP;
                        end else begin
                            make_nx = 1'b1;
                            code_nx = {1'b0, din};
                        end
                    end
                    EXT_ST: begin
                        if (din == KBD_BRK) begin
                            state_nx = EXT_BRK_ST;
                        end else if (din == KBD_EXT) begin
                            state_nx = EXT_ST;
                        end else if (din == KBD_FAKE_SHIFT || din == KBD_PAUSE) begin
                            state_nx = IDLE_ST;
                        end else begin
                            make_nx  = 1'b1;
                            code_nx  = {1'b1, din};
                            state_nx = IDLE_ST;
                        end
                    end
                    BRK_ST: begin
                        state_nx = IDLE_ST;
                        if (din != KBD_EXT && din != KBD_BRK && din != KBD_PAUSE) begin
                            brakk_nx = 1'b1;
                            code_nx  = {1'b0, din};
                        end
                    end
                    EXT_BRK_ST: begin
                        state_nx = IDLE_ST;
                        if (din != KBD_FAKE_SHIFT && din != KBD_EXT &&
                            din != KBD_BRK && din != KBD_PAUSE) begin
                            brakk_nx = 1'b1;
                            code_nx  = {1'b1, din};
                        end
                    end
                    PAUSE_ST: begin
                        skip_nx = skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) begin
                            make_nx  = 1'b1;
                            code_nx  = PAUSE_CODE;
                            state_nx = IDLE_ST;
                        end
                    end
                    default: begin
                        state_nx = IDLE_ST;
                        skip_nx  = '0;
                    end
                endcase
            end
        end else if (state != IDLE_ST && idle_cnt == TO_LAST) begin
            state_nx = IDLE_ST;
            skip_nx  = '0;
        end
    end

    // State, counters and registered event outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= IDLE_ST;
            skip_cnt <= '0;
            idle_cnt <= '0;
            keyCode  <= '0;
            make     <= 1'b0;
            brakk    <= 1'b0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
            idle_cnt <= idle_nx;
            keyCode  <= code_nx;
            make     <= make_nx;
            brakk    <= brakk_nx;
        end
    end

    assign busy = (state != IDLE_ST);

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// Scoreboard bench for kbd_scancode_decoder: directed scan-code sequences.
module tb_kbd_scancode_decoder;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [7:0] din = '0;
    logic       new_din = 1'b0;
    logic [8:0] keyCode;
    logic       make;
    logic       brakk;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Expected events: bit 9 = 1 for make, 0 for break; bits 8:0 = keyCode.
    logic [9:0] exp_q[$];

    kbd_scancode_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .resetN  (resetN),
        .din     (din),
        .new_din (new_din),
        .keyCode (keyCode),
        .make    (make),
        .brakk   (brakk),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        din     = b;
        new_din = 1'b1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            new_din = 1'b0;
        end
    endtask

    task automatic expect_make(input logic [8:0] code);
        exp_q.push_back({1'b1, code});
    endtask

    task automatic expect_brk(input logic [8:0] code);
        exp_q.push_back({1'b0, code});
    endtask

    // Monitor: every event pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (resetN && (make || brakk)) begin
            logic [9:0] e;
            if (make && brakk) begin
                checks++;
                failures++;
                $display("FAIL both_pulses: make=%b brakk=%b", make, brakk);
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: make=%b brakk=%b keyCode=%h", make, brakk, keyCode);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (make !== e[9] || keyCode !== e[8:0]) begin
                    failures++;
                    $display("FAIL event: got make=%b code=%h expected make=%b code=%h",
                             make, keyCode, e[9], e[8:0]);
                end
            end
        end
    end

    task automatic drain(input string name);
        idle(3);
        chk(name, 16'(exp_q.size()), 16'd0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_keycode", 16'(keyCode), 16'h000);
        chk("reset_make",    16'(make),    16'd0);
        chk("reset_brakk",   16'(brakk),   16'd0);
        chk("reset_busy",    16'(busy),    16'd0);
        resetN = 1'b1;
        idle(2);

        // Plain make
        expect_make(9'h01C);
        send_byte(8'h1C);
        idle(1);
        chk("make_busy", 16'(busy), 16'd0);
        chk("make_code_held", 16'(keyCode), 16'h01C);
        drain("plain_make");

        // Break
        send_byte(8'hF0);
        idle(1);
        chk("brk_busy", 16'(busy), 16'd1);
        expect_brk(9'h01C);
        send_byte(8'h1C);
        idle(1);
        chk("brk_busy_clear", 16'(busy), 16'd0);
        drain("break");

        // Extended break and make, back-to-back
        expect_brk(9'h175);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        expect_make(9'h175);
        send_byte(8'hE0); send_byte(8'h75);
        drain("ext_b2b");

        // Print Screen make and release
        expect_make(9'h17C);
        send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h7C);
        expect_brk(9'h17C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h7C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
        idle(1);
        chk("prtsc_busy", 16'(busy), 16'd0);
        drain("prtsc");

        // Pause: single make on the 8th byte
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0);
        idle(1);
        chk("pause_busy_mid", 16'(busy), 16'd1);
        expect_make(9'h177);
        send_byte(8'h77);
        idle(1);
        chk("pause_busy_after", 16'(busy), 16'd0);
        drain("pause");

        // Ignored bytes, including aborting a prefix
        send_byte(8'hFA); send_byte(8'hAA);
        send_byte(8'hE0); send_byte(8'hFA);
        idle(1);
        chk("ign_abort_busy", 16'(busy), 16'd0);
        chk("ign_code_held", 16'(keyCode), 16'h177);
        drain("ignored");

        // Timeout: busy holds through T cycles, drops just after
        send_byte(8'hE0);
        idle(T);
        chk("to_busy_before", 16'(busy), 16'd1);
        idle(1);
        chk("to_busy_after", 16'(busy), 16'd0);
        expect_make(9'h01C);
        send_byte(8'h1C);
        drain("timeout");

        // Byte on the terminal-count cycle is processed normally
        send_byte(8'hE0);
        idle(T - 1);
        expect_make(9'h175);
        send_byte(8'h75);
        drain("timeout_tie");

        // Reset mid-sequence
        send_byte(8'hF0);
        @(negedge clk);
        new_din = 1'b0;
        resetN  = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        chk("midreset_busy", 16'(busy), 16'd0);
        chk("midreset_code", 16'(keyCode), 16'h000);
        expect_make(9'h01C);
        send_byte(8'h1C);
        drain("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
